// File: rtl/obstacle_scheduler.sv
// Row-ordered ring buffer of generated obstacles; once per frame it retires
// rows behind the player and streams every in-view entry to game_logic.
module obstacle_scheduler #(
   parameter int DEPTH             = 16,
   parameter int HALF_BLOCK_LENGTH = 64,
   parameter int VIEW_ROWS         = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       new_frame,
   input  logic [15:0]                player_score,
   input  logic                       game_over,
   input  logic [15:0]                gen_obstacle,
   input  logic [15:0]                gen_row,
   input  logic                       gen_valid,
   output logic                       gen_ready,
   output logic [15:0]                obstacle,
   output logic [15:0]                obstacle_row,
   output logic                       obstacle_valid,
   output logic                       firstrow,
   output logic                       sweep_done,
   output logic                       overrun,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int SHIFT = $clog2(HALF_BLOCK_LENGTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RETIRE,
      ST_SWEEP,
      ST_DONE
   } state_t;

   state_t state, next_state;

   logic [15:0]      mem_obs [DEPTH];
   logic [15:0]      mem_row [DEPTH];
   logic [PTR_W-1:0] head, tail, rd_ptr;
   logic [CNT_W-1:0] count, idx;
   logic [15:0]      cur_row, view_last;
   logic             push, pop, issue, frame_accept;

   assign gen_ready = (count < CNT_W'(DEPTH)) && !game_over;
   assign push      = gen_valid && gen_ready;
   assign rd_ptr    = head + idx[PTR_W-1:0];
   assign view_last = cur_row + 16'(VIEW_ROWS - 1);
   assign occupancy = count;
   assign sweep_done = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state   = state;
      pop          = 1'b0;
      issue        = 1'b0;
      frame_accept = 1'b0;
      case (state)
         ST_IDLE: begin
            if (new_frame && !game_over) begin
               frame_accept = 1'b1;
               next_state   = ST_RETIRE;
            end
         end
         ST_RETIRE: begin
            if ((count != '0) && (mem_row[head] < cur_row)) pop = 1'b1;
            else                                            next_state = ST_SWEEP;
         end
         ST_SWEEP: begin
            // count is live, so entries pushed during the sweep may also issue
            if ((idx < count) && (mem_row[rd_ptr] <= view_last)) issue = 1'b1;
            else                                                 next_state = ST_DONE;
         end
         ST_DONE:  next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_obs[tail] <= gen_obstacle;
         mem_row[tail] <= gen_row;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         idx            <= '0;
         cur_row        <= '0;
         overrun        <= 1'b0;
         obstacle       <= '0;
         obstacle_row   <= '0;
         obstacle_valid <= 1'b0;
         firstrow       <= 1'b0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (frame_accept) begin
            cur_row <= player_score >> SHIFT;
            idx     <= '0;
         end else if (issue) begin
            idx <= idx + 1'b1;
         end
         if (new_frame && (state != ST_IDLE)) overrun <= 1'b1;
         obstacle_valid <= issue;
         if (issue) begin
            obstacle     <= mem_obs[rd_ptr];
            obstacle_row <= mem_row[rd_ptr];
            firstrow     <= (mem_row[rd_ptr] == cur_row);
         end
      end
   end

endmodule
